// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester round-robin ALU with a single registered result slot
// Combinational grant and ALU; the result register is an EMPTY/FULL slot drained by res_ready.
module alu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [N-1:0] res_data,
  output logic         res_carry,
  output logic         res_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state_q, state_d;
  logic         last_gnt_q, last_gnt_d;
  logic         id_q, id_d;
  logic [N-1:0] data_q, data_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;

  logic         free, grant0, grant1, xfer0, xfer1;
  logic [2:0]   sel_op;
  logic [N-1:0] sel_a, sel_b;
  logic [N:0]   wide;

  // last_gnt_q == 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    free       = (state_q == EMPTY) || res_ready;
    grant0     = req0_valid && (!req1_valid || last_gnt_q);
    grant1     = req1_valid && (!req0_valid || !last_gnt_q);
    req0_ready = grant0 && free && rst_n;
    req1_ready = grant1 && free && rst_n;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
  end

  always_comb begin
    sel_op = xfer1 ? req1_op : req0_op;
    sel_a  = xfer1 ? req1_a  : req0_a;
    sel_b  = xfer1 ? req1_b  : req0_b;
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    data_d     = data_q;
    carry_d    = carry_q;
    err_d      = err_q;
    wide       = '0;

    case (state_q)
      EMPTY:   if (xfer0 || xfer1) state_d = FULL;
      FULL:    if (!(xfer0 || xfer1) && res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (xfer0 || xfer1) begin
      id_d       = xfer1;
      last_gnt_d = xfer1;
      carry_d    = 1'b0;
      err_d      = 1'b0;
      case (sel_op)
        3'b000:  data_d = sel_a & sel_b;
        3'b001:  data_d = sel_a | sel_b;
        3'b010:  data_d = sel_a ^ sel_b;
        3'b011:  data_d = ~sel_a;
        3'b100: begin
          wide    = {1'b0, sel_a} + {1'b0, sel_b};
          data_d  = wide[N-1:0];
          carry_d = wide[N];
        end
        // The extra top bit of an N+1-bit subtraction is exactly the unsigned borrow.
        3'b101: begin
          wide    = {1'b0, sel_a} - {1'b0, sel_b};
          data_d  = wide[N-1:0];
          carry_d = wide[N];
        end
        3'b110:  data_d = sel_a;
        default: begin
          data_d = '0;
          err_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      data_q     <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      id_q       <= id_d;
      data_q     <= data_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = id_q;
  assign res_data  = data_q;
  assign res_carry = carry_q;
  assign res_err   = err_q;

endmodule
